// File: rtl/bus_gate_arbiter.sv
// bus_gate_arbiter
//
// Registered shared-bus driver for the datapath sources (MARMUX, PC, ALU, MDR, ...).
// Each cycle one gated source is chosen, either by fixed priority or by round-robin.
// The chosen source's data is driven onto the bus with one cycle of latency. The
// current owner can be held across cycles with lock. Cycles where more than one
// gate is high are flagged and counted in a saturating counter.
//
// Parameters:
//   WIDTH  bit width of each source and of the bus
//   N      number of gated sources (2..16)
//   MODE   0 = fixed priority (lowest index wins), 1 = round-robin
//   HOLD   1 = Dout keeps its last value when idle, 0 = Dout cleared when idle
//   CW     width of the conflict counter
//
// Ports:
//   Clk             system clock, rising edge
//   Reset_n         asynchronous active-low reset
//   gate            per-source gate request
//   data_in         flattened source data, source i at [i*WIDTH +: WIDTH]
//   lock            keep the current owner while its gate stays high
//   clear_conflict  synchronous clear of conflict_cnt
//   Dout            registered bus value
//   grant           registered one-hot owner, zero when idle
//   valid           registered, high when a source drove Dout
//   conflict        registered pulse, more than one gate high at the sampling edge
//   conflict_cnt    saturating count of conflict cycles
module bus_gate_arbiter #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned N     = 4,
   parameter int unsigned MODE  = 0,
   parameter int unsigned HOLD  = 1,
   parameter int unsigned CW    = 8
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic [N-1:0]       gate,
   input  logic [N*WIDTH-1:0] data_in,
   input  logic               lock,
   input  logic               clear_conflict,
   output logic [WIDTH-1:0]   Dout,
   output logic [N-1:0]       grant,
   output logic               valid,
   output logic               conflict,
   output logic [CW-1:0]      conflict_cnt
);

   localparam int unsigned IW = $clog2(N);

   localparam logic [0:0] StIdle  = 1'b0;
   localparam logic [0:0] StOwned = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    ptr_q, ptr_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [N-1:0]     grant_q, grant_d;
   logic             valid_q, valid_d;
   logic             conflict_q, conflict_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [IW-1:0]    win_idx;
   logic             win_found;
   logic [IW-1:0]    cand;
   logic [IW-1:0]    sel;
   logic             locked;
   logic [WIDTH-1:0] sel_data;

   // Arbitration winner among the current gates.
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = ptr_q;
      if (MODE == 0) begin
         // Walk downward so the lowest set index is written last.
         for (int i = N - 1; i >= 0; i--) begin
            if (gate[i]) begin
               win_idx   = IW'(i);
               win_found = 1'b1;
            end
         end
      end else begin
         // Search upward from the pointer with an explicit wrap at N-1.
         for (int unsigned off = 0; off < N; off++) begin
            if (!win_found && gate[cand]) begin
               win_idx   = cand;
               win_found = 1'b1;
            end
            cand = (cand == IW'(N - 1)) ? '0 : cand + 1'b1;
         end
      end
   end

   assign locked = (state_q == StOwned) && lock && gate[owner_q];
   assign sel    = locked ? owner_q : win_idx;

   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (sel == IW'(i)) begin
            sel_data = data_in[i*WIDTH +: WIDTH];
         end
      end
   end

   // Owner state, bus value and round-robin pointer.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      dout_d  = dout_q;
      grant_d = '0;
      valid_d = 1'b0;
      if (gate == '0) begin
         state_d = StIdle;
         if (HOLD == 0) begin
            dout_d = '0;
         end
      end else begin
         state_d      = StOwned;
         owner_d      = sel;
         dout_d       = sel_data;
         grant_d[sel] = 1'b1;
         valid_d      = 1'b1;
         // A locked hold leaves the pointer where it was.
         if (!locked) begin
            ptr_d = (sel == IW'(N - 1)) ? '0 : sel + 1'b1;
         end
      end
   end

   // More than one bit set iff clearing the lowest set bit leaves something behind.
   assign conflict_d = (gate & (gate - 1'b1)) != '0;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_conflict) begin
         cnt_d = CW'(conflict_d);
      end else if (conflict_d && (cnt_q != {CW{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q    <= StIdle;
         owner_q    <= '0;
         ptr_q      <= '0;
         dout_q     <= '0;
         grant_q    <= '0;
         valid_q    <= 1'b0;
         conflict_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         ptr_q      <= ptr_d;
         dout_q     <= dout_d;
         grant_q    <= grant_d;
         valid_q    <= valid_d;
         conflict_q <= conflict_d;
         cnt_q      <= cnt_d;
      end
   end

   assign Dout         = dout_q;
   assign grant        = grant_q;
   assign valid        = valid_q;
   assign conflict     = conflict_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Self-checking bench for bus_gate_arbiter. Two instances share the stimulus:
// dut_p (fixed priority, HOLD=1, CW=8) and dut_r (round-robin, HOLD=0, CW=2).
// A behavioural model tracks owner, pointer and counters for each instance.
module tb_bus_gate_arbiter;

   localparam int unsigned W = 16;
   localparam int unsigned N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   gate = '0;
   logic [N*W-1:0] data = '0;
   logic           lock = 1'b0;
   logic           clr = 1'b0;

   logic [W-1:0] dout_p, dout_r;
   logic [N-1:0] grant_p, grant_r;
   logic         valid_p, valid_r, conf_p, conf_r;
   logic [7:0]   cnt_p;
   logic [1:0]   cnt_r;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   bus_gate_arbiter #(.WIDTH(W), .N(N), .MODE(0), .HOLD(1), .CW(8)) dut_p (
      .Clk(clk), .Reset_n(rst_n), .gate(gate), .data_in(data), .lock(lock),
      .clear_conflict(clr), .Dout(dout_p), .grant(grant_p), .valid(valid_p),
      .conflict(conf_p), .conflict_cnt(cnt_p)
   );

   bus_gate_arbiter #(.WIDTH(W), .N(N), .MODE(1), .HOLD(0), .CW(2)) dut_r (
      .Clk(clk), .Reset_n(rst_n), .gate(gate), .data_in(data), .lock(lock),
      .clear_conflict(clr), .Dout(dout_r), .grant(grant_r), .valid(valid_r),
      .conflict(conf_r), .conflict_cnt(cnt_r)
   );

   // Reference model state, index 0 = dut_p, 1 = dut_r.
   int        p_mode[2] = '{0, 1};
   int        p_hold[2] = '{1, 0};
   int        p_max[2]  = '{255, 3};
   bit        m_owned[2];
   int        m_owner[2];
   int        m_ptr[2];
   int        m_dout[2];
   int        m_grant[2];
   int        m_valid[2];
   int        m_conf[2];
   int        m_cnt[2];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      for (int j = 0; j < 2; j++) begin
         m_owned[j] = 0; m_owner[j] = 0; m_ptr[j] = 0; m_dout[j] = 0;
         m_grant[j] = 0; m_valid[j] = 0; m_conf[j] = 0; m_cnt[j] = 0;
      end
   endtask

   // One rising edge of the model using the inputs present at that edge.
   task automatic model_step();
      int pop, w;
      pop = $countones(gate);
      for (int j = 0; j < 2; j++) begin
         if (pop == 0) begin
            m_owned[j] = 0;
            m_valid[j] = 0;
            m_grant[j] = 0;
            if (p_hold[j] == 0) m_dout[j] = 0;
         end else begin
            if (m_owned[j] && lock && gate[m_owner[j]]) begin
               w = m_owner[j];
            end else begin
               w = -1;
               for (int k = 0; k < N; k++) begin
                  int c;
                  c = (p_mode[j] == 0) ? k : (m_ptr[j] + k) % N;
                  if (w < 0 && gate[c]) w = c;
               end
               m_ptr[j] = (w + 1) % N;
            end
            m_owned[j] = 1;
            m_owner[j] = w;
            m_dout[j]  = int'(data[w*W +: W]);
            m_grant[j] = 1 << w;
            m_valid[j] = 1;
         end
         m_conf[j] = (pop >= 2) ? 1 : 0;
         if (clr) m_cnt[j] = m_conf[j];
         else if (m_conf[j] == 1 && m_cnt[j] < p_max[j]) m_cnt[j]++;
      end
   endtask

   task automatic check_all();
      check("p_dout",  64'(dout_p),  64'(m_dout[0]));
      check("p_grant", 64'(grant_p), 64'(m_grant[0]));
      check("p_valid", 64'(valid_p), 64'(m_valid[0]));
      check("p_conf",  64'(conf_p),  64'(m_conf[0]));
      check("p_cnt",   64'(cnt_p),   64'(m_cnt[0]));
      check("r_dout",  64'(dout_r),  64'(m_dout[1]));
      check("r_grant", 64'(grant_r), 64'(m_grant[1]));
      check("r_valid", 64'(valid_r), 64'(m_valid[1]));
      check("r_conf",  64'(conf_r),  64'(m_conf[1]));
      check("r_cnt",   64'(cnt_r),   64'(m_cnt[1]));
   endtask

   task automatic step();
      @(posedge clk);
      if (rst_n) model_step();
      @(negedge clk);
      check_all();
   endtask

   initial begin
      logic [N-1:0] rr_exp [6];
      rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      model_reset();

      // Reset held with all gates high and toggling data.
      @(negedge clk);
      check_all();
      for (int i = 0; i < 4; i++) begin
         gate = 4'b1111;
         data = {$urandom, $urandom};
         step();
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Single gate, fixed priority.
      data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA};
      gate = 4'b0100;
      step();
      check("single_dout", 64'(dout_p), 64'h CCCC);
      check("single_grant", 64'(grant_p), 64'b0100);

      // Priority conflict for three cycles, then idle.
      gate = 4'b1010;
      for (int i = 0; i < 3; i++) step();
      check("conf_cnt3", 64'(cnt_p), 64'd3);
      gate = 4'b0000;
      step();
      check("hold_dout", 64'(dout_p), 64'h BBBB);
      check("nohold_dout", 64'(dout_r), 64'h0);

      // Reset asserted mid-burst clears outputs before the next edge.
      gate = 4'b1111;
      step();
      @(posedge clk);
      model_step();
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Round-robin sweep with every gate high.
      gate = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         step();
         check("rr_seq", 64'(grant_r), 64'(rr_exp[i]));
      end

      // Lock holds source 0, data change mid-lock appears next edge.
      gate = 4'b0000;
      step();
      gate = 4'b0011;
      lock = 1'b1;
      data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
      for (int i = 0; i < 4; i++) begin
         if (i == 2) data[15:0] = 16'h1234;
         step();
         check("lock_grant", 64'(grant_r), 64'b0001);
      end
      check("lock_data", 64'(dout_r), 64'h1234);
      gate = 4'b0010;
      step();
      check("unlock_grant", 64'(grant_r), 64'b0010);
      lock = 1'b0;

      // Counter saturation and clear priority.
      clr = 1'b1;
      gate = 4'b0000;
      step();
      clr = 1'b0;
      gate = 4'b0110;
      for (int i = 0; i < 5; i++) step();
      check("cnt_sat", 64'(cnt_r), 64'd3);
      clr = 1'b1;
      step();
      check("clr_conf", 64'(cnt_r), 64'd1);
      gate = 4'b0001;
      step();
      check("clr_only", 64'(cnt_r), 64'd0);
      clr = 1'b0;

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         gate = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
         lock = ($urandom_range(0, 3) != 0);
         clr  = ($urandom_range(0, 19) == 0);
         data = {$urandom, $urandom};
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/bus_gate_arbiter.md
# bus_gate_arbiter

Registered, parametrised successor to the datapath bus gate selector. It takes N gated sources of WIDTH bits each and drives a single shared bus value, with either fixed-priority or round-robin arbitration. Ownership can be locked across cycles, and multi-gate conflicts are detected and counted. It sits between the SLC-3 datapath sources (MARMUX, PC, ALU, MDR and future additions) and every bus consumer. It replaces the combinational tri-state emulation with a one-cycle-latency, glitch-free bus register.

## Interface
- WIDTH, 16, bit width of each source and of the bus
- N, 4, number of gated sources (2..16); index 0 = MARMUX, 1 = PC, 2 = ALU, 3 = MDR when N=4
- MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- HOLD, 1, 1 = Dout keeps the last driven value when idle; 0 = Dout forced to 0 when idle
- CW, 8, width of the conflict counter

- Clk  in  1  system clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- gate  in  N  per-source gate request
- data_in  in  N*WIDTH  flattened source data; source i occupies bits [i*WIDTH +: WIDTH]
- lock  in  1  keep the current owner while its gate stays high
- clear_conflict  in  1  synchronous clear of conflict_cnt
- Dout  out  WIDTH  registered bus value
- grant  out  N  registered one-hot owner; all zero when idle
- valid  out  1  registered; 1 when some source drove Dout this cycle
- conflict  out  1  registered one-cycle pulse: more than one gate was high at the sampling edge
- conflict_cnt  out  CW  saturating count of conflict cycles

## Operation
- Reset (Reset_n low, asynchronous): Dout=0, grant=0, valid=0, conflict=0, conflict_cnt=0, round-robin pointer=0, owner state cleared to IDLE.
- Owner state machine, evaluated every rising edge:
  - IDLE: no owner.
  - OWNED(k): source k won the previous cycle.
  - Any state, gate==0 → IDLE. valid=0, grant=0. Dout holds its value if HOLD=1, else becomes 0.
  - OWNED(k), lock=1, gate[k]=1 → stays OWNED(k). Winner is k regardless of other gates; the round-robin pointer is not advanced.
  - Otherwise, with gate≠0 → OWNED(w), where w is the arbitration winner.
- Arbitration winner w:
  - MODE=0: lowest set index of gate.
  - MODE=1: first set index searching upward from the pointer, wrapping from N-1 to 0.
  - After a non-locked grant to w, pointer = (w+1) mod N, with wrap at N-1 → 0.
  - Pointer is unused in MODE=0.
- On any grant: Dout = data_in slice w, grant = one-hot(w), valid = 1.
- Conflict detection:
  - conflict = 1 iff popcount(gate) ≥ 2, independent of lock or MODE.
  - conflict_cnt increments by 1 per conflict cycle and saturates at 2^CW−1, never wrapping.
  - clear_conflict=1 takes priority: conflict_cnt becomes 1 if a conflict occurs that same cycle, else 0.
- Data path: data is sampled from data_in at the same edge as gate. A change in the owner's data while it is locked is reflected on the next edge.
- No output is ever X or Z after reset.

## Timing
- All outputs are registered.
- Inputs sampled at edge n appear on Dout, grant, valid and conflict after edge n: one-cycle latency, and a single-cycle bus owner gets exactly one valid cycle.
- Back-to-back grants to different sources need no idle cycle between them.
- Reset assertion mid-operation clears outputs immediately, without waiting for Clk.
- Reset deassertion is synchronised externally. The first sampling edge after release behaves as from IDLE, with pointer=0.
- lock has no effect in IDLE or when gate[k]=0. It never creates a grant by itself.

## Test plan
- Reset: hold Reset_n=0, drive gate=4'b1111 with toggling data → Dout=0, grant=0, valid=0, conflict_cnt=0 throughout; assert Reset_n low mid-burst → outputs 0 before the next edge.
- Priority, single gate (MODE=0, N=4): data_in={16'hDDDD,16'hCCCC,16'hBBBB,16'hAAAA}, gate=4'b0100 at edge n → after edge n Dout=16'hCCCC, grant=4'b0100, valid=1, conflict=0.
- Priority conflict: gate=4'b1010 for 3 cycles → Dout=16'hBBBB, grant=4'b0010, conflict=1 each cycle, conflict_cnt=3; then gate=0 → valid=0, Dout stays 16'hBBBB (HOLD=1), or is 0 with HOLD=0.
- Round-robin (MODE=1): gate=4'b1111 held for 6 cycles → grant sequence 0001, 0010, 0100, 1000, 0001, 0010; pointer wraps from 3 to 0.
- Lock: MODE=1, gate=4'b0011, lock=1 from the first grant for 4 cycles → grant=4'b0001 all 4 cycles. Drop gate[0] → next grant=4'b0010. Change data_in slice 0 mid-lock → new value on Dout one edge later.
- Counter boundaries: CW=2, conflicts for 5 cycles → conflict_cnt=3, saturated. clear_conflict together with a conflict cycle → 1. clear_conflict alone → 0.
